// File: rtl/hardwired_control_unit.sv
// Hardwired control sequencer for the single-bus datapath.
// Steps fetch (T0-T2) and the per-class execute sequence (T3-T6),
// decoding the opcode in IR[31:27] and driving the datapath strobes.
module hardwired_control_unit #(
    parameter int NUM_REGS = 16,
    parameter int ALU_OP_W = 5
) (
    input  logic                Clock,
    input  logic                Clear,
    input  logic [31:0]         IR,
    input  logic                Mem_ready,
    input  logic                Stop,
    output logic                PCout,
    output logic                Zlowout,
    output logic                ZHighout,
    output logic                MDRout,
    output logic                MARin,
    output logic                PCin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                ZLowIn,
    output logic                ZHighIn,
    output logic                HIin,
    output logic                LOin,
    output logic                IncPC,
    output logic                Read,
    output logic [ALU_OP_W-1:0] ALU_op,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic                Run,
    output logic                Illegal
);

    typedef enum logic [2:0] {
        T0, T1, T2, T3, T4, T5, T6, HALTED
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t state;
    state_t next_state;
    logic   active;

    logic [4:0] opcode;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       is_alu;
    logic       is_muldiv;
    logic       is_unary;
    logic       is_nop;
    logic       is_halt;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign unused_ir = ^IR[14:0];

    // One-hot register select; indices beyond the register file select nothing.
    function automatic logic [NUM_REGS-1:0] reg_sel(input logic [3:0] idx);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(idx) == i) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Classify the opcode into its execute-sequence family.
    always_comb begin
        is_alu    = 1'b0;
        is_muldiv = 1'b0;
        is_unary  = 1'b0;
        is_nop    = 1'b0;
        is_halt   = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR: is_alu    = 1'b1;
            OP_MUL, OP_DIV:                is_muldiv = 1'b1;
            OP_NEG, OP_NOT:                is_unary  = 1'b1;
            OP_NOP:                        is_nop    = 1'b1;
            OP_HALT:                       is_halt   = 1'b1;
            default:                       ;
        endcase
    end

    // State register; the first edge after reset only arms the sequencer so
    // that the T0 cycle proper begins on that edge.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state  <= T0;
            active <= 1'b0;
        end else begin
            active <= 1'b1;
            if (active) begin
                state <= next_state;
            end
        end
    end

    // Next-state sequencing; Stop is honoured only when leaving a final execute state.
    always_comb begin
        next_state = state;
        case (state)
            T0: next_state = T1;
            T1: if (Mem_ready) next_state = T2;
            T2: next_state = T3;
            T3: begin
                if (is_halt)                    next_state = HALTED;
                else if (is_alu || is_muldiv || is_unary) next_state = T4;
                else                            next_state = Stop ? HALTED : T0;
            end
            T4: begin
                if (is_alu || is_muldiv) next_state = T5;
                else                     next_state = Stop ? HALTED : T0;
            end
            T5: begin
                if (is_muldiv) next_state = T6;
                else           next_state = Stop ? HALTED : T0;
            end
            T6:      next_state = Stop ? HALTED : T0;
            HALTED:  next_state = HALTED;
            default: next_state = T0;
        endcase
    end

    // Strobe decode from state and IR; everything is quiet until armed.
    always_comb begin
        PCout    = 1'b0;
        Zlowout  = 1'b0;
        ZHighout = 1'b0;
        MDRout   = 1'b0;
        MARin    = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        ZLowIn   = 1'b0;
        ZHighIn  = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        ALU_op   = '0;
        Rin      = '0;
        Rout     = '0;
        Illegal  = 1'b0;
        Run      = (state != HALTED);
        if (active) begin
            case (state)
                T0: begin
                    PCout  = 1'b1;
                    MARin  = 1'b1;
                    IncPC  = 1'b1;
                    ZLowIn = 1'b1;
                end
                T1: begin
                    Zlowout = 1'b1;
                    Read    = 1'b1;
                    MDRin   = 1'b1;
                    PCin    = Mem_ready;
                end
                T2: begin
                    MDRout = 1'b1;
                    IRin   = 1'b1;
                end
                T3: begin
                    if (is_alu) begin
                        Rout = reg_sel(rb);
                        Yin  = 1'b1;
                    end else if (is_muldiv) begin
                        Rout = reg_sel(ra);
                        Yin  = 1'b1;
                    end else if (is_unary) begin
                        Rout   = reg_sel(rb);
                        ALU_op = ALU_OP_W'(opcode);
                        ZLowIn = 1'b1;
                    end else if (!is_nop && !is_halt) begin
                        Illegal = 1'b1;
                    end
                end
                T4: begin
                    if (is_alu) begin
                        Rout   = reg_sel(rc);
                        ALU_op = ALU_OP_W'(opcode);
                        ZLowIn = 1'b1;
                    end else if (is_muldiv) begin
                        Rout    = reg_sel(rb);
                        ALU_op  = ALU_OP_W'(opcode);
                        ZLowIn  = 1'b1;
                        ZHighIn = 1'b1;
                    end else if (is_unary) begin
                        Zlowout = 1'b1;
                        Rin     = reg_sel(ra);
                    end
                end
                T5: begin
                    if (is_alu) begin
                        Zlowout = 1'b1;
                        Rin     = reg_sel(ra);
                    end else if (is_muldiv) begin
                        Zlowout = 1'b1;
                        LOin    = 1'b1;
                    end
                end
                T6: begin
                    if (is_muldiv) begin
                        ZHighout = 1'b1;
                        HIin     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hardwired_control_unit.sv
// Self-checking bench for hardwired_control_unit: table of per-cycle vectors
// plus hand-written reset, halt and mid-instruction Clear sequences.
module tb_hardwired_control_unit;

    logic        Clock;
    logic        Clear;
    logic [31:0] IR;
    logic        Mem_ready;
    logic        Stop;
    logic        PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin;
    logic        Yin, ZLowIn, ZHighIn, HIin, LOin, IncPC, Read;
    logic [4:0]  ALU_op;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic        Run;
    logic        Illegal;

    int total = 0;
    int bad   = 0;

    localparam logic [14:0] S_PCOUT    = 15'h4000;
    localparam logic [14:0] S_ZLOWOUT  = 15'h2000;
    localparam logic [14:0] S_ZHIGHOUT = 15'h1000;
    localparam logic [14:0] S_MDROUT   = 15'h0800;
    localparam logic [14:0] S_MARIN    = 15'h0400;
    localparam logic [14:0] S_PCIN     = 15'h0200;
    localparam logic [14:0] S_MDRIN    = 15'h0100;
    localparam logic [14:0] S_IRIN     = 15'h0080;
    localparam logic [14:0] S_YIN      = 15'h0040;
    localparam logic [14:0] S_ZLOWIN   = 15'h0020;
    localparam logic [14:0] S_ZHIGHIN  = 15'h0010;
    localparam logic [14:0] S_HIIN     = 15'h0008;
    localparam logic [14:0] S_LOIN     = 15'h0004;
    localparam logic [14:0] S_INCPC    = 15'h0002;
    localparam logic [14:0] S_READ     = 15'h0001;

    localparam logic [14:0] F_T0   = S_PCOUT | S_MARIN | S_INCPC | S_ZLOWIN;
    localparam logic [14:0] F_T1W  = S_ZLOWOUT | S_READ | S_MDRIN;
    localparam logic [14:0] F_T1   = S_ZLOWOUT | S_READ | S_MDRIN | S_PCIN;
    localparam logic [14:0] F_T2   = S_MDROUT | S_IRIN;

    localparam logic [31:0] IR_AND  = 32'h4A920000;
    localparam logic [31:0] IR_MUL  = 32'h79200000;
    localparam logic [31:0] IR_NEG  = {5'b10001, 4'd1, 4'd3, 4'd0, 15'd0};
    localparam logic [31:0] IR_BAD  = {5'b11111, 4'd6, 4'd7, 4'd8, 15'd0};
    localparam logic [31:0] IR_NOP  = {5'b11010, 27'd0};
    localparam logic [31:0] IR_ADD  = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};
    localparam logic [31:0] IR_HALT = {5'b11011, 27'd0};

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic        mr;
        logic        stop;
        logic [14:0] strb;
        logic [4:0]  alu;
        logic [15:0] rin;
        logic [15:0] rout;
        logic        run;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    hardwired_control_unit #(.NUM_REGS(16), .ALU_OP_W(5)) dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .Mem_ready(Mem_ready), .Stop(Stop),
        .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin),
        .IncPC(IncPC), .Read(Read), .ALU_op(ALU_op), .Rin(Rin), .Rout(Rout),
        .Run(Run), .Illegal(Illegal)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic vec_t mk(input string n, input logic [31:0] ir, input logic mr,
                                input logic st, input logic [14:0] s, input logic [4:0] a,
                                input logic [15:0] ri, input logic [15:0] ro,
                                input logic run, input logic ill);
        vec_t v;
        v.name = n; v.ir = ir; v.mr = mr; v.stop = st; v.strb = s; v.alu = a;
        v.rin = ri; v.rout = ro; v.run = run; v.ill = ill;
        return v;
    endfunction

    // Drive inputs for the coming cycle, just after the active edge.
    task automatic applyStimulus(input logic [31:0] ir, input logic mr, input logic st);
        @(posedge Clock);
        #1;
        IR        = ir;
        Mem_ready = mr;
        Stop      = st;
    endtask

    // Compare every DUT output against the expected record.
    task automatic checkOutput(input string n, input logic [14:0] s, input logic [4:0] a,
                               input logic [15:0] ri, input logic [15:0] ro,
                               input logic run, input logic ill);
        logic [14:0] got;
        got = {PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin,
               Yin, ZLowIn, ZHighIn, HIin, LOin, IncPC, Read};
        total++;
        if (got !== s || ALU_op !== a || Rin !== ri || Rout !== ro ||
            Run !== run || Illegal !== ill) begin
            bad++;
            $display("[TB] FAIL %s: got strb=%h alu=%h rin=%h rout=%h run=%b ill=%b, want strb=%h alu=%h rin=%h rout=%h run=%b ill=%b",
                     n, got, ALU_op, Rin, Rout, Run, Illegal, s, a, ri, ro, run, ill);
        end
    endtask

    task automatic doReset();
        @(negedge Clock);
        Clear = 1'b0;
        #1;
        checkOutput("reset_async", 15'h0, 5'h0, 16'h0, 16'h0, 1'b1, 1'b0);
        @(negedge Clock);
        Clear = 1'b1;
        #1;
        checkOutput("reset_released", 15'h0, 5'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    endtask

    initial begin
        Clear = 1'b0; IR = 32'h0; Mem_ready = 1'b0; Stop = 1'b0;

        // and R5,R2,R4 with memory ready immediately (Mem_ready in T0 is ignored)
        vecs.push_back(mk("and_t0", IR_AND, 1, 0, F_T0, 0, 0, 0, 1, 0));
        vecs.push_back(mk("and_t1", IR_AND, 1, 0, F_T1, 0, 0, 0, 1, 0));
        vecs.push_back(mk("and_t2", IR_AND, 1, 0, F_T2, 0, 0, 0, 1, 0));
        vecs.push_back(mk("and_t3", IR_AND, 1, 0, S_YIN, 0, 0, 16'h0004, 1, 0));
        vecs.push_back(mk("and_t4", IR_AND, 1, 0, S_ZLOWIN, 5'b01001, 0, 16'h0010, 1, 0));
        vecs.push_back(mk("and_t5", IR_AND, 1, 0, S_ZLOWOUT, 0, 16'h0020, 0, 1, 0));
        // mul R2,R4 with three wait cycles on the read
        vecs.push_back(mk("mul_t0", IR_MUL, 0, 0, F_T0, 0, 0, 0, 1, 0));
        vecs.push_back(mk("mul_t1w1", IR_MUL, 0, 0, F_T1W, 0, 0, 0, 1, 0));
        vecs.push_back(mk("mul_t1w2", IR_MUL, 0, 0, F_T1W, 0, 0, 0, 1, 0));
        vecs.push_back(mk("mul_t1w3", IR_MUL, 0, 0, F_T1W, 0, 0, 0, 1, 0));
        vecs.push_back(mk("mul_t1", IR_MUL, 1, 0, F_T1, 0, 0, 0, 1, 0));
        vecs.push_back(mk("mul_t2", IR_MUL, 0, 0, F_T2, 0, 0, 0, 1, 0));
        vecs.push_back(mk("mul_t3", IR_MUL, 0, 0, S_YIN, 0, 0, 16'h0004, 1, 0));
        vecs.push_back(mk("mul_t4", IR_MUL, 0, 0, S_ZLOWIN | S_ZHIGHIN, 5'b01111, 0, 16'h0010, 1, 0));
        vecs.push_back(mk("mul_t5", IR_MUL, 0, 0, S_ZLOWOUT | S_LOIN, 0, 0, 0, 1, 0));
        vecs.push_back(mk("mul_t6", IR_MUL, 0, 0, S_ZHIGHOUT | S_HIIN, 0, 0, 0, 1, 0));
        // neg R1,R3
        vecs.push_back(mk("neg_t0", IR_NEG, 1, 0, F_T0, 0, 0, 0, 1, 0));
        vecs.push_back(mk("neg_t1", IR_NEG, 1, 0, F_T1, 0, 0, 0, 1, 0));
        vecs.push_back(mk("neg_t2", IR_NEG, 1, 0, F_T2, 0, 0, 0, 1, 0));
        vecs.push_back(mk("neg_t3", IR_NEG, 1, 0, S_ZLOWIN, 5'b10001, 0, 16'h0008, 1, 0));
        vecs.push_back(mk("neg_t4", IR_NEG, 1, 0, S_ZLOWOUT, 0, 16'h0002, 0, 1, 0));
        // undefined opcode 11111
        vecs.push_back(mk("bad_t0", IR_BAD, 1, 0, F_T0, 0, 0, 0, 1, 0));
        vecs.push_back(mk("bad_t1", IR_BAD, 1, 0, F_T1, 0, 0, 0, 1, 0));
        vecs.push_back(mk("bad_t2", IR_BAD, 1, 0, F_T2, 0, 0, 0, 1, 0));
        vecs.push_back(mk("bad_t3", IR_BAD, 1, 0, 15'h0, 0, 0, 0, 1, 1));
        // nop
        vecs.push_back(mk("nop_t0", IR_NOP, 1, 0, F_T0, 0, 0, 0, 1, 0));
        vecs.push_back(mk("nop_t1", IR_NOP, 1, 0, F_T1, 0, 0, 0, 1, 0));
        vecs.push_back(mk("nop_t2", IR_NOP, 1, 0, F_T2, 0, 0, 0, 1, 0));
        vecs.push_back(mk("nop_t3", IR_NOP, 1, 0, 15'h0, 0, 0, 0, 1, 0));
        // add R1,R2,R3 with Stop raised mid-execute; it must complete first
        vecs.push_back(mk("add_t0", IR_ADD, 1, 0, F_T0, 0, 0, 0, 1, 0));
        vecs.push_back(mk("add_t1", IR_ADD, 1, 0, F_T1, 0, 0, 0, 1, 0));
        vecs.push_back(mk("add_t2", IR_ADD, 1, 0, F_T2, 0, 0, 0, 1, 0));
        vecs.push_back(mk("add_t3", IR_ADD, 1, 1, S_YIN, 0, 0, 16'h0004, 1, 0));
        vecs.push_back(mk("add_t4", IR_ADD, 1, 1, S_ZLOWIN, 5'b00011, 0, 16'h0008, 1, 0));
        vecs.push_back(mk("add_t5", IR_ADD, 1, 1, S_ZLOWOUT, 0, 16'h0002, 0, 1, 0));
        vecs.push_back(mk("stop_halted1", IR_ADD, 1, 0, 15'h0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("stop_halted2", IR_NOP, 1, 0, 15'h0, 0, 0, 0, 0, 0));

        doReset();
        foreach (vecs[k]) begin
            applyStimulus(vecs[k].ir, vecs[k].mr, vecs[k].stop);
            @(negedge Clock);
            checkOutput(vecs[k].name, vecs[k].strb, vecs[k].alu, vecs[k].rin,
                        vecs[k].rout, vecs[k].run, vecs[k].ill);
        end

        // halt instruction with Stop also high: ends in HALTED and stays there
        doReset();
        applyStimulus(IR_HALT, 1, 1);
        @(negedge Clock);
        checkOutput("halt_t0", F_T0, 0, 0, 0, 1, 0);
        applyStimulus(IR_HALT, 1, 1);
        applyStimulus(IR_HALT, 1, 1);
        applyStimulus(IR_HALT, 1, 1);
        @(negedge Clock);
        checkOutput("halt_t3", 15'h0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(IR_ADD, i[0], 0);
            @(negedge Clock);
            checkOutput($sformatf("halt_stay%0d", i), 15'h0, 0, 0, 0, 0, 0);
        end

        // Clear during T4 of an add: outputs drop at once, restart at T0
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(IR_ADD, 1, 0);
        end
        @(negedge Clock);
        checkOutput("clr_t4", S_ZLOWIN, 5'b00011, 0, 16'h0008, 1, 0);
        #1;
        Clear = 1'b0;
        #1;
        checkOutput("clr_async", 15'h0, 0, 0, 0, 1, 0);
        @(negedge Clock);
        Clear = 1'b1;
        applyStimulus(IR_ADD, 1, 0);
        @(negedge Clock);
        checkOutput("clr_restart_t0", F_T0, 0, 0, 0, 1, 0);
        applyStimulus(IR_ADD, 1, 0);
        @(negedge Clock);
        checkOutput("clr_restart_t1", F_T1, 0, 0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends even if the stimulus stalls.
    initial begin
        #20000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
